stopwatch_lap: RTL and testbench
================================

STOPWATCH_LAP -- requirements
Module: stopwatch_lap

Interface
REQ-001 Parameter TICK_DIV, default 500000, SHALL set clk cycles per 10 ms tick; legal range >= 2.
REQ-002 Parameter MIN_MAX, default 60, SHALL set the minute modulus; legal range 1..100.
REQ-003 clk  in  1  SHALL be the single clock; all logic rises on posedge clk.
REQ-004 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 start_stop_p  in  1  SHALL be a single-cycle, already-debounced pulse that toggles run/stop.
REQ-006 lap_p  in  1  SHALL be a single-cycle, already-debounced pulse for lap, release or clear.
REQ-007 load_p  in  1  SHALL be a single-cycle pulse that loads the preset.
REQ-008 dir_down  in  1  SHALL select counting direction: 0 = up, 1 = down.
REQ-009 preset_min  in  7  SHALL be the binary minutes preset.
REQ-010 preset_sec  in  6  SHALL be the binary seconds preset.
REQ-011 disp_bcd  out  24  SHALL carry the displayed digits as BCD, one digit per nibble, {min_tens, min_unit, sec_tens, sec_unit, cs_tens, cs_unit}, MSB first.
REQ-012 running  out  1  SHALL be 1 while counting.
REQ-013 lap_active  out  1  SHALL be 1 while the display is frozen on a lap snapshot.
REQ-014 tick  out  1  SHALL be a one-cycle pulse on each applied 10 ms step.
REQ-015 done  out  1  SHALL be a one-cycle pulse when a down-count reaches zero.

Function
REQ-016 The prescaler SHALL be $clog2(TICK_DIV) bits wide, SHALL count only while running=1, and SHALL wrap from TICK_DIV-1 to 0, asserting tick on that cycle.
REQ-017 When running stops, the prescaler SHALL hold its value, so that resuming continues the partial period.
REQ-018 Load and clear SHALL zero the prescaler.
REQ-019 Live time SHALL be held as BCD digits with ranges cs 00..99, sec 00..59 and min 00..MIN_MAX-1.
REQ-020 Up mode, on tick: cs increments; carry 99->00 increments sec; carry 59->00 increments min; MIN_MAX-1:59.99 -> 00:00.00 wraps all digits to zero in a single tick; running stays 1.
REQ-021 Down mode, on tick: decrement with borrow; 00.00 cs borrows from sec, and 00 sec borrows from min (sec -> 59, cs -> 99).
REQ-022 Down mode: the tick that produces 00:00.00 SHALL clear running on the next edge and SHALL pulse done on that same cycle; the count never underflows.
REQ-023 The direction SHALL be latched from dir_down on a stop->run transition; dir_down changes while running SHALL be ignored.
REQ-024 start_stop_p SHALL toggle running, effective on the next edge.
REQ-025 start_stop_p while stopped, with dir_down=1 and live time zero, SHALL be ignored (running stays 0).
REQ-026 lap_p while running SHALL toggle lap_active; a 0->1 transition SHALL capture a snapshot of the live time on that edge.
REQ-027 lap_p while stopped with lap_active=1 SHALL clear lap_active only.
REQ-028 lap_p while stopped with lap_active=0 SHALL clear the live time and the prescaler to zero.
REQ-029 load_p while stopped SHALL set min = min(preset_min, MIN_MAX-1), sec = min(preset_sec, 59) and cs = 00, converted to BCD.
REQ-030 load_p while running SHALL be ignored.
REQ-031 disp_bcd SHALL equal the snapshot when lap_active=1 and the live time otherwise; it SHALL be registered, with one cycle latency from the live or snapshot update.
REQ-032 Same-cycle pulses SHALL be prioritised start_stop_p > lap_p > load_p; lower-priority pulses in that cycle SHALL be discarded.
REQ-033 A tick coinciding with start_stop_p stopping the count SHALL still be applied.
REQ-034 While running, the live time SHALL keep counting when lap_active=1.

Reset
REQ-035 rst_n=0 SHALL immediately force: live time, snapshot, disp_bcd and prescaler = 0; running, lap_active, tick and done = 0; latched direction = up.
REQ-036 Reset asserted mid-count SHALL abort without a done pulse.
REQ-037 After rst_n deasserts, the first start_stop_p SHALL be honoured on the first following edge.

Verification (TICK_DIV=4, MIN_MAX=60)
REQ-038 Up count: reset, start_stop_p, run 400 cycles -> disp_bcd = 00:01.00; tick pulses = 100; running=1.
REQ-039 Up-mode wrap: load 59:59 (cs=00) while stopped, start_stop_p, run 400 cycles -> disp_bcd returns to 00:00.00 on the 100th tick; running=1.
REQ-040 Down count to zero: dir_down=1, load preset_min=0, preset_sec=1, start_stop_p, run -> done single pulse on the 100th tick; running=0; disp_bcd = 00:00.00; a further start_stop_p is ignored.
REQ-041 Lap freeze: running up, lap_p at 00:00.50 -> disp_bcd holds 00:00.50 while live time advances; second lap_p -> display shows live time within 1 cycle.
REQ-042 Priority and saturation: start_stop_p and lap_p in the same cycle while running -> running=0, lap_active unchanged; load with preset_min=99, preset_sec=63 -> disp_bcd = 59:59.00.
REQ-043 Async reset: assert rst_n=0 mid-count between clk edges -> all outputs 0 before the next edge; no done pulse.

Source files
------------

// File: rtl/stopwatch_lap.sv
// Stopwatch with lap freeze, preset load and up/down counting.
// Live time and lap snapshot are held as BCD mm:ss.cc; the display is registered.
module stopwatch_lap #(
    parameter int TICK_DIV = 500000,
    parameter int MIN_MAX  = 60
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_stop_p,
    input  logic        lap_p,
    input  logic        load_p,
    input  logic        dir_down,
    input  logic [6:0]  preset_min,
    input  logic [5:0]  preset_sec,
    output logic [23:0] disp_bcd,
    output logic        running,
    output logic        lap_active,
    output logic        tick,
    output logic        done
);

    localparam int              PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [3:0]      MAX_MT     = 4'((MIN_MAX - 1) / 10);
    localparam logic [3:0]      MAX_MU     = 4'((MIN_MAX - 1) % 10);
    localparam logic [6:0]      MIN_LAST   = 7'(MIN_MAX - 1);

    typedef struct packed {
        logic [3:0] mt;
        logic [3:0] mu;
        logic [3:0] st;
        logic [3:0] su;
        logic [3:0] ct;
        logic [3:0] cu;
    } bcd_time_t;

    typedef enum logic {ST_STOP, ST_RUN} state_t;

    state_t        state_q, state_d;
    bcd_time_t     live_q, live_d, snap_q, snap_d, preset_t;
    logic [PW-1:0] presc_q, presc_d;
    logic          lap_q, lap_d, dir_q, dir_d;
    logic [23:0]   disp_q;
    logic          live_zero, live_one, start_ok;
    logic [6:0]    min_sat;
    logic [5:0]    sec_sat;

    function automatic bcd_time_t time_inc(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.cu != 4'd9) r.cu = t.cu + 4'd1;
        else begin
            r.cu = 4'd0;
            if (t.ct != 4'd9) r.ct = t.ct + 4'd1;
            else begin
                r.ct = 4'd0;
                if (t.su != 4'd9) r.su = t.su + 4'd1;
                else begin
                    r.su = 4'd0;
                    if (t.st != 4'd5) r.st = t.st + 4'd1;
                    else begin
                        r.st = 4'd0;
                        if (t.mt == MAX_MT && t.mu == MAX_MU) begin
                            r.mt = 4'd0;
                            r.mu = 4'd0;
                        end else if (t.mu != 4'd9) r.mu = t.mu + 4'd1;
                        else begin
                            r.mu = 4'd0;
                            r.mt = t.mt + 4'd1;
                        end
                    end
                end
            end
        end
        return r;
    endfunction

    // Only called on a non-zero time, so the minute tens never underflow.
    function automatic bcd_time_t time_dec(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.cu != 4'd0) r.cu = t.cu - 4'd1;
        else begin
            r.cu = 4'd9;
            if (t.ct != 4'd0) r.ct = t.ct - 4'd1;
            else begin
                r.ct = 4'd9;
                if (t.su != 4'd0) r.su = t.su - 4'd1;
                else begin
                    r.su = 4'd9;
                    if (t.st != 4'd0) r.st = t.st - 4'd1;
                    else begin
                        r.st = 4'd5;
                        if (t.mu != 4'd0) r.mu = t.mu - 4'd1;
                        else begin
                            r.mu = 4'd9;
                            r.mt = t.mt - 4'd1;
                        end
                    end
                end
            end
        end
        return r;
    endfunction

    assign live_zero = (live_q == bcd_time_t'(24'h000000));
    assign live_one  = (live_q == bcd_time_t'(24'h000001));
    assign start_ok  = !(dir_down && live_zero);

    always_comb begin
        min_sat  = (preset_min > MIN_LAST) ? MIN_LAST : preset_min;
        sec_sat  = (preset_sec > 6'd59) ? 6'd59 : preset_sec;
        preset_t = '{mt: 4'(min_sat / 7'd10), mu: 4'(min_sat % 7'd10),
                     st: 4'(sec_sat / 6'd10), su: 4'(sec_sat % 6'd10),
                     ct: 4'd0, cu: 4'd0};
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_STOP;
        else        state_q <= state_d;
    end

    // NOTE: every output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STOP: if (start_stop_p && start_ok)  state_d = ST_RUN;
            ST_RUN:  if (start_stop_p || done)      state_d = ST_STOP;
            default: state_d = ST_STOP;
        endcase
    end

    always_comb begin
        running    = (state_q == ST_RUN);
        lap_active = lap_q;
        tick       = running && (presc_q == PRESC_LAST);
        done       = tick && dir_q && live_one;
    end

    // Tick is applied before pulse handling, so a stop in the tick cycle still counts it.
    always_comb begin
        live_d  = live_q;
        snap_d  = snap_q;
        lap_d   = lap_q;
        presc_d = presc_q;
        dir_d   = dir_q;
        if (running) presc_d = tick ? '0 : presc_q + 1'b1;
        if (tick)    live_d  = dir_q ? time_dec(live_q) : time_inc(live_q);
        if (start_stop_p) begin
            if (!running && start_ok) dir_d = dir_down;
        end else if (lap_p) begin
            if (running) begin
                lap_d = !lap_q;
                if (!lap_q) snap_d = live_q;
            end else if (lap_q) begin
                lap_d = 1'b0;
            end else begin
                live_d  = '0;
                presc_d = '0;
            end
        end else if (load_p && !running) begin
            live_d  = preset_t;
            presc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q  <= '0;
            snap_q  <= '0;
            lap_q   <= 1'b0;
            presc_q <= '0;
            dir_q   <= 1'b0;
            disp_q  <= '0;
        end else begin
            live_q  <= live_d;
            snap_q  <= snap_d;
            lap_q   <= lap_d;
            presc_q <= presc_d;
            dir_q   <= dir_d;
            disp_q  <= lap_q ? snap_q : live_q;
        end
    end

    assign disp_bcd = disp_q;

endmodule

// File: tb/tb_stopwatch_lap.sv
// Scoreboard bench for stopwatch_lap with TICK_DIV=4, MIN_MAX=60.
// Expectations are queued at a negedge and compared by the monitor 1 time unit later.
module tb_stopwatch_lap;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_stop_p = 1'b0;
    logic        lap_p = 1'b0;
    logic        load_p = 1'b0;
    logic        dir_down = 1'b0;
    logic [6:0]  preset_min = '0;
    logic [5:0]  preset_sec = '0;
    logic [23:0] disp_bcd;
    logic        running, lap_active, tick, done;

    int n_cmp = 0;
    int n_err = 0;
    int tick_cnt = 0;
    int done_cnt = 0;
    int base_tick, base_done;

    string       name_q[$];
    int          kind_q[$];
    logic [31:0] exp_q[$];

    localparam int K_DISP = 0, K_RUN = 1, K_LAP = 2, K_TCNT = 3, K_DCNT = 4,
                   K_TICK = 5, K_DONE = 6;

    stopwatch_lap #(.TICK_DIV(4), .MIN_MAX(60)) dut (
        .clk(clk), .rst_n(rst_n), .start_stop_p(start_stop_p), .lap_p(lap_p),
        .load_p(load_p), .dir_down(dir_down), .preset_min(preset_min),
        .preset_sec(preset_sec), .disp_bcd(disp_bcd), .running(running),
        .lap_active(lap_active), .tick(tick), .done(done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tick === 1'b1) tick_cnt++;
        if (done === 1'b1) done_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic expect_val(input string name, input int kind, input logic [31:0] exp);
        name_q.push_back(name);
        kind_q.push_back(kind);
        exp_q.push_back(exp);
    endtask

    initial begin
        logic [31:0] act;
        forever begin
            @(negedge clk);
            #1;
            while (kind_q.size() > 0) begin
                case (kind_q[0])
                    K_DISP:  act = {8'h00, disp_bcd};
                    K_RUN:   act = 32'(running);
                    K_LAP:   act = 32'(lap_active);
                    K_TCNT:  act = 32'(tick_cnt);
                    K_DCNT:  act = 32'(done_cnt);
                    K_TICK:  act = 32'(tick);
                    default: act = 32'(done);
                endcase
                check(name_q[0], act, exp_q[0]);
                void'(name_q.pop_front());
                void'(kind_q.pop_front());
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_ss();
        start_stop_p = 1'b1;
        @(negedge clk);
        start_stop_p = 1'b0;
    endtask

    task automatic pulse_lap();
        lap_p = 1'b1;
        @(negedge clk);
        lap_p = 1'b0;
    endtask

    task automatic pulse_load(input logic [6:0] m, input logic [5:0] s);
        preset_min = m;
        preset_sec = s;
        load_p = 1'b1;
        @(negedge clk);
        load_p = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, %0d compared", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        @(negedge clk);
        expect_val("rst_disp", K_DISP, 32'h0);
        expect_val("rst_running", K_RUN, 32'd0);
        expect_val("rst_lap", K_LAP, 32'd0);
        expect_val("rst_tick", K_TICK, 32'd0);
        expect_val("rst_done", K_DONE, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(2);

        // Up count for 400 running cycles; mid-run dir_down change ignored
        base_tick = tick_cnt;
        pulse_ss();
        cyc(199);
        dir_down = 1'b1;
        cyc(200);
        expect_val("up_running", K_RUN, 32'd1);
        expect_val("up_ticks", K_TCNT, 32'(base_tick + 100));
        pulse_ss();
        dir_down = 1'b0;
        cyc(1);
        expect_val("up_disp", K_DISP, 32'h000100);
        expect_val("up_stopped", K_RUN, 32'd0);
        pulse_lap();
        cyc(1);
        expect_val("clear_disp", K_DISP, 32'h0);

        // Up-mode wrap from 59:59.00
        pulse_load(7'd59, 6'd59);
        cyc(1);
        expect_val("load_5959", K_DISP, 32'h595900);
        pulse_ss();
        cyc(399);
        expect_val("wrap_before", K_DISP, 32'h595999);
        expect_val("wrap_running0", K_RUN, 32'd1);
        cyc(2);
        expect_val("wrap_disp", K_DISP, 32'h0);
        expect_val("wrap_running1", K_RUN, 32'd1);
        pulse_ss();
        pulse_lap();

        // Down count 00:01.00 to zero
        dir_down = 1'b1;
        pulse_load(7'd0, 6'd1);
        base_done = done_cnt;
        pulse_ss();
        cyc(399);
        expect_val("down_done_pulse", K_DONE, 32'd1);
        expect_val("down_running", K_RUN, 32'd1);
        cyc(2);
        expect_val("down_stopped", K_RUN, 32'd0);
        expect_val("down_disp", K_DISP, 32'h0);
        expect_val("down_done_cnt", K_DCNT, 32'(base_done + 1));
        pulse_ss();
        cyc(2);
        expect_val("down_start_ignored", K_RUN, 32'd0);
        dir_down = 1'b0;

        // Lap freeze at 00:00.50, release at 00:00.75
        pulse_lap();
        pulse_ss();
        cyc(201);
        pulse_lap();
        cyc(100);
        expect_val("lap_frozen", K_DISP, 32'h000050);
        expect_val("lap_active1", K_LAP, 32'd1);
        pulse_lap();
        expect_val("lap_active0", K_LAP, 32'd0);
        cyc(1);
        expect_val("lap_release", K_DISP, 32'h000075);

        // start_stop_p outranks lap_p; load saturates
        start_stop_p = 1'b1;
        lap_p = 1'b1;
        @(negedge clk);
        start_stop_p = 1'b0;
        lap_p = 1'b0;
        expect_val("prio_running", K_RUN, 32'd0);
        expect_val("prio_lap", K_LAP, 32'd0);
        pulse_load(7'd99, 6'd63);
        cyc(1);
        expect_val("load_sat", K_DISP, 32'h595900);

        // Load ignored while running, then async reset mid-count
        pulse_ss();
        cyc(50);
        pulse_load(7'd0, 6'd0);
        cyc(10);
        expect_val("load_ignored", K_DISP, 32'h595915);
        expect_val("pre_rst_running", K_RUN, 32'd1);
        cyc(1);
        base_done = done_cnt;
        rst_n = 1'b0;
        expect_val("arst_disp", K_DISP, 32'h0);
        expect_val("arst_running", K_RUN, 32'd0);
        expect_val("arst_lap", K_LAP, 32'd0);
        expect_val("arst_tick", K_TICK, 32'd0);
        expect_val("arst_done", K_DONE, 32'd0);
        cyc(3);
        rst_n = 1'b1;
        pulse_ss();
        expect_val("post_rst_start", K_RUN, 32'd1);
        expect_val("arst_no_done", K_DCNT, 32'(base_done));
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
